// File: rtl/mem_arb_pkg.sv
// Shared types and address-map helpers for the two-port Memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StErr,
    StDrain
  } arb_state_e;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  localparam logic [10:0] REGION_SRAM = 11'h0;
  localparam logic [10:0] REGION_SD   = 11'h1;

  // Only the SRAM and SD-window regions are backed by Memory.
  function automatic logic is_mapped(input logic [31:0] addr);
    return (addr[31:21] == REGION_SRAM) || (addr[31:21] == REGION_SD);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; the last-grant history lives in the parent.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_port
);

  always_comb begin
    grant_valid = |eligible;
    grant_port  = PORT_IFETCH;
    if (&eligible) begin
      grant_port = ~last_grant;
    end else if (eligible[PORT_DATA]) begin
      grant_port = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide Memory port between instruction
// fetch (port 0) and load/store (port 1), with local decode and timeout abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic [7:0]  p0_rdata,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic [7:0]  p1_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_in_data,
  input  logic [7:0]  mem_out_data,
  output logic        mem_sig_read,
  output logic        mem_sig_write,
  input  logic        mem_ready
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic             sig_read_q, sig_read_d;
  logic             sig_write_q, sig_write_d;
  logic [7:0]       p0_rdata_q, p0_rdata_d;
  logic [7:0]       p1_rdata_q, p1_rdata_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_in_data_q, mem_in_data_d;

  logic [1:0]  eligible;
  logic        grant_valid;
  logic        grant_port;
  logic [31:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        sel_we;

  // A port whose ack is high is dropping req; keep it out of this cycle's pick.
  assign eligible = {p1_req & ~ack_q[PORT_DATA], p0_req & ~ack_q[PORT_IFETCH]};

  mem_arb_rr u_rr (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  assign sel_addr  = (grant_port == PORT_DATA) ? p1_addr  : p0_addr;
  assign sel_wdata = (grant_port == PORT_DATA) ? p1_wdata : p0_wdata;
  assign sel_we    = (grant_port == PORT_DATA) ? p1_we    : p0_we;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    ack_d         = '0;
    err_d         = '0;
    sig_read_d    = 1'b0;
    sig_write_d   = 1'b0;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_in_data_d = mem_in_data_q;

    unique case (state_q)
      StIdle: begin
        if (mem_ready && grant_valid) begin
          gnt_d         = grant_port;
          last_grant_d  = grant_port;
          mem_addr_d    = sel_addr;
          mem_in_data_d = sel_wdata;
          if (is_mapped(sel_addr)) begin
            sig_read_d  = ~sel_we;
            sig_write_d = sel_we;
            state_d     = StIssue;
          end else begin
            state_d = StErr;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mem_ready) begin
          ack_d[gnt_q] = 1'b1;
          if (gnt_q == PORT_DATA) p1_rdata_d = mem_out_data;
          else                    p0_rdata_d = mem_out_data;
          state_d = StIdle;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          state_d      = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErr: begin
        ack_d[gnt_q] = 1'b1;
        err_d[gnt_q] = 1'b1;
        if (gnt_q == PORT_DATA) p1_rdata_d = 8'h00;
        else                    p0_rdata_d = 8'h00;
        state_d = StIdle;
      end
      StDrain: begin
        // The aborted access is still in flight inside Memory; let it finish.
        if (mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      last_grant_q  <= PORT_DATA;
      gnt_q         <= PORT_IFETCH;
      cnt_q         <= '0;
      ack_q         <= '0;
      err_q         <= '0;
      sig_read_q    <= 1'b0;
      sig_write_q   <= 1'b0;
      p0_rdata_q    <= 8'h00;
      p1_rdata_q    <= 8'h00;
      mem_addr_q    <= 32'h0;
      mem_in_data_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      sig_read_q    <= sig_read_d;
      sig_write_q   <= sig_write_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_in_data_q <= mem_in_data_d;
    end
  end

  assign p0_ack        = ack_q[PORT_IFETCH];
  assign p0_err        = err_q[PORT_IFETCH];
  assign p0_rdata      = p0_rdata_q;
  assign p1_ack        = ack_q[PORT_DATA];
  assign p1_err        = err_q[PORT_DATA];
  assign p1_rdata      = p1_rdata_q;
  assign mem_addr      = mem_addr_q;
  assign mem_in_data   = mem_in_data_q;
  assign mem_sig_read  = sig_read_q;
  assign mem_sig_write = sig_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic
// against a behavioural Memory and a shadow-memory reference.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_in_data, mem_out_data;
  logic        mem_sig_read, mem_sig_write, mem_ready;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .p0_req        (p0_req),
    .p0_we         (p0_we),
    .p0_addr       (p0_addr),
    .p0_wdata      (p0_wdata),
    .p0_rdata      (p0_rdata),
    .p0_ack        (p0_ack),
    .p0_err        (p0_err),
    .p1_req        (p1_req),
    .p1_we         (p1_we),
    .p1_addr       (p1_addr),
    .p1_wdata      (p1_wdata),
    .p1_rdata      (p1_rdata),
    .p1_ack        (p1_ack),
    .p1_err        (p1_err),
    .mem_addr      (mem_addr),
    .mem_in_data   (mem_in_data),
    .mem_out_data  (mem_out_data),
    .mem_sig_read  (mem_sig_read),
    .mem_sig_write (mem_sig_write),
    .mem_ready     (mem_ready)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 16) return 8'hA5;
    return 8'(i * 37 + 11);
  endfunction

  // SRAM and SD window folded into one small array: {addr[21], addr[10:0]}.
  function automatic int midx(input logic [31:0] a);
    return int'({a[21], a[10:0]});
  endfunction

  // ---------------- Memory model ----------------
  // One busy cycle for SRAM, 1..5 for SD; sd_stall freezes an SD access.
  // out_data after a write is the byte just written.
  logic [7:0]  mem_arr [0:4095];
  logic        mem_init = 1'b0;
  logic        sd_stall = 1'b0;
  logic        cur_sd;
  int          busy_cnt;
  logic [7:0]  pend_data;
  int          n_access = 0;
  int          last_acc_cyc = 0;
  logic [31:0] last_acc_addr = 32'h0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= init_val(i);
      mem_init <= 1'b1;
    end
    if (!reset_n) begin
      mem_ready    <= 1'b1;
      mem_out_data <= 8'h00;
      busy_cnt     <= 0;
      cur_sd       <= 1'b0;
    end else if (mem_sig_read || mem_sig_write) begin
      if (mem_sig_write) mem_arr[midx(mem_addr)] <= mem_in_data;
      pend_data     <= mem_sig_write ? mem_in_data : mem_arr[midx(mem_addr)];
      mem_ready     <= 1'b0;
      cur_sd        <= mem_addr[21];
      busy_cnt      <= mem_addr[21] ? int'($urandom_range(0, 4)) : 0;
      n_access      <= n_access + 1;
      last_acc_cyc  <= cyc;
      last_acc_addr <= mem_addr;
    end else if (!mem_ready) begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      else if (!(cur_sd && sd_stall)) begin
        mem_ready    <= 1'b1;
        mem_out_data <= pend_data;
      end
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    logic       err;
    logic       chk_rdata;
    logic [7:0] rdata;
    int         t0;
    int         lat;
  } exp_t;

  typedef struct {
    int port;
    int cyc;
  } ack_ev_t;

  exp_t       q0[$];
  exp_t       q1[$];
  ack_ev_t    ack_log[$];
  logic [7:0] shadow [0:4095];
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_mapped_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic check_ack(input int port, input logic err, input logic [7:0] rdata);
    exp_t e;
    ack_log.push_back('{port, cyc});
    if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
      n_checks++;
      $display("FAIL unexpected_ack_p%0d: actual ack=1 required ack=0 (cycle %0d)", port, cyc);
      return;
    end
    if (port == 0) e = q0.pop_front();
    else           e = q1.pop_front();
    chk($sformatf("p%0d_err", port), 32'(err), 32'(e.err));
    if (e.chk_rdata) chk($sformatf("p%0d_rdata", port), 32'(rdata), 32'(e.rdata));
    if (e.lat != 0) chk($sformatf("p%0d_latency", port), 32'(cyc - e.t0), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (p0_ack) check_ack(0, p0_err, p0_rdata);
      if (p1_ack) check_ack(1, p1_err, p1_rdata);
      if (p0_err) chk("p0_err_without_ack", 32'(p0_ack), 1);
      if (p1_err) chk("p1_err_without_ack", 32'(p1_ack), 1);
      if (p0_ack || p1_ack) chk("single_ack", 32'(p0_ack & p1_ack), 0);
      if (mem_sig_read || mem_sig_write) begin
        chk("issue_while_busy", 32'(mem_ready), 1);
        chk("both_sigs", 32'(mem_sig_read & mem_sig_write), 0);
        chk("issue_unmapped", 32'(mem_addr[31:22]), 0);
      end
    end
  end

  // ---------------- Drivers ----------------
  // Call at posedge+#1. Returns at posedge+#1 of the ack cycle with req still high.
  task automatic p_do(input int port, input logic we, input logic [31:0] addr,
                      input logic [7:0] wd, input int lat, input bit timeout_exp,
                      output int t_req, output int t_ack);
    exp_t e;
    bit   mapped;
    int   n;
    mapped      = (addr[31:21] <= 11'd1);
    e.err       = !mapped || timeout_exp;
    e.chk_rdata = !timeout_exp;
    if (!mapped) e.rdata = 8'h00;
    else if (we) begin
      e.rdata = wd;
      shadow[midx(addr)] = wd;
    end else e.rdata = shadow[midx(addr)];
    e.t0  = cyc;
    e.lat = lat;
    if (mapped) n_mapped_exp++;
    if (port == 0) begin
      q0.push_back(e);
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
    end else begin
      q1.push_back(e);
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
    end
    t_req = cyc;
    t_ack = -1;
    n = 0;
    while (t_ack < 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if ((port == 0) ? p0_ack : p1_ack) t_ack = cyc;
    end
    if (t_ack < 0) begin
      n_checks++;
      $display("FAIL p%0d_ack_timeout: actual no ack required ack within 300 cycles", port);
    end
  endtask

  task automatic p_gap(input int port, input int n);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_port(input int port, input int count);
    int          tr, ta, r, gap;
    logic [31:0] a, base;
    logic        we;
    base = (port == 0) ? 32'h0 : 32'h100;
    for (int i = 0; i < count; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = base + 32'($urandom_range(0, 255));
      else if (r < 9) a = 32'h0020_0000 + base + 32'($urandom_range(0, 255));
      else            a = {11'($urandom_range(2, 2047)), 21'($urandom)};
      we = (port == 1) && ($urandom_range(0, 1) == 1);
      p_do(port, we, a, 8'($urandom), 0, 1'b0, tr, ta);
      gap = int'($urandom_range(0, 3));
      if (gap > 0) p_gap(port, gap);
    end
    p_gap(port, 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ctl"}, 32'({p0_ack, p0_err, p1_ack, p1_err, mem_sig_read, mem_sig_write}), 0);
    chk({tag, "_rdata"}, 32'({p0_rdata, p1_rdata}), 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, 32'(mem_in_data), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  int tr0, ta0, tr1, ta1, rel, acc0;

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
    reset_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 8'h00;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: solo SRAM read
    p_do(0, 1'b0, 32'h10, 8'h00, 4, 1'b0, tr0, ta0);
    p_gap(0, 1);
    chk("t1_issue_addr", last_acc_addr, 32'h10);
    chk("t1_issue_cycle", 32'(last_acc_cyc - tr0), 1);

    // 2: both ports saturating; port 0 won last, so port 1 takes the tie
    ack_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) p_do(0, 1'b0, 32'h4, 8'h00, 0, 1'b0, tr0, ta0);
        p_gap(0, 1);
      end
      begin
        for (int j = 0; j < 4; j++) p_do(1, 1'b1, 32'h5, 8'h3C, 0, 1'b0, tr1, ta1);
        p_gap(1, 1);
      end
    join
    chk("t2_ack_count", 32'(ack_log.size()), 8);
    if (ack_log.size() == 8) begin
      chk("t2_first_port", 32'(ack_log[0].port), 1);
      for (int k = 1; k < 8; k++) begin
        chk("t2_alternate", 32'(ack_log[k].port != ack_log[k-1].port), 1);
        chk("t2_spacing", 32'(ack_log[k].cyc - ack_log[k-1].cyc), 4);
      end
    end
    chk("t2_sram_byte5", 32'(mem_arr[5]), 32'h3C);

    // 3: unmapped write
    acc0 = n_access;
    p_do(1, 1'b1, 32'h0040_0000, 8'h77, 2, 1'b0, tr1, ta1);
    p_gap(1, 1);
    chk("t3_no_access", 32'(n_access - acc0), 0);

    // 4: SD stall -> timeout, port 1 waits for the drain
    sd_stall = 1'b1;
    rel = 0;
    fork
      begin
        p_do(0, 1'b0, 32'h0020_0003, 8'h00, TIMEOUT + 2, 1'b1, tr0, ta0);
        p_gap(0, 3);
        rel = cyc;
        sd_stall = 1'b0;
      end
      begin
        @(posedge clk); #1;
        p_do(1, 1'b0, 32'h100, 8'h00, 0, 1'b0, tr1, ta1);
        p_gap(1, 1);
      end
    join
    chk("t4_p1_after_release", 32'(ta1 > rel), 1);

    // 5: reset in WAIT
    @(posedge clk); #1;
    p0_we = 1'b0; p0_addr = 32'h20; p0_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    p0_req = 1'b0;
    @(posedge clk); #1;
    check_reset_state("t5_reset");
    reset_n = 1'b1;
    n_mapped_exp++;  // the interrupted read had already reached Memory
    repeat (3) begin @(posedge clk); #1; end
    p_do(0, 1'b0, 32'h20, 8'h00, 4, 1'b0, tr0, ta0);
    p_gap(0, 1);

    // 6: req held across the ack cycle
    acc0 = n_access;
    p_do(0, 1'b0, 32'h30, 8'h00, 4, 1'b0, tr0, ta0);
    p_do(0, 1'b0, 32'h30, 8'h00, 5, 1'b0, tr0, ta0);
    p_gap(0, 2);
    chk("t6_accesses", 32'(n_access - acc0), 2);

    // randomized traffic on both ports
    fork
      rand_port(0, 60);
      rand_port(1, 60);
    join
    repeat (5) begin @(posedge clk); #1; end

    chk("total_accesses", 32'(n_access), 32'(n_mapped_exp));
    chk("p0_queue_empty", 32'(q0.size()), 0);
    chk("p1_queue_empty", 32'(q1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
